m2fm_field_writer: RTL
======================

Name: m2fm_field_writer

Overview:
Serial M2FM field transmitter for the write path, and the write-side counterpart of the F77A sync detector. On `start` it emits one complete field as a bit stream toward the flux write stage, in this order:
- a zero-byte preamble, M2FM encoded;
- the raw 16-bit sync pattern, unencoded;
- N payload bytes pulled through a ready/valid handshake, M2FM encoded;
- a CRC-16 over the payload, M2FM encoded.

The block sits between the sector buffer and the write precompensation / flux driver and is paced by the write bit-cell strobe.

Parameters:
- PREAMBLE_BYTES, 6: number of 0x00 bytes emitted before sync (1..63).
- SYNC_PATTERN, 16'hF77A: raw sync bits, sent MSB first with no clock insertion.
- CRC_POLY, 16'h1021: CRC-16 generator polynomial.
- CRC_INIT, 16'hFFFF: CRC preset, applied at sync end.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  when low: state, counters and outputs hold; bit_tick is ignored
- start  in  1  single-cycle pulse; starts a field when idle
- byte_count  in  10  payload length N, latched at start; 0 is legal
- bit_tick  in  1  single-cycle strobe, one per encoded bit (2x data rate)
- data_in  in  8  payload byte
- data_valid  in  1  payload byte available
- data_ready  out  1  writer will accept a byte this cycle
- flux_out  out  1  encoded bit
- flux_valid  out  1  pulses for one cycle per emitted bit
- busy  out  1  field in progress
- done  out  1  single-cycle pulse after the last CRC bit
- underrun  out  1  sticky; cleared on accepted start

Behaviour:
- Reset (asynchronous, reset_n low): all outputs 0, state IDLE, prev_data=0, holding register empty, CRC=CRC_INIT.
- States: IDLE -> PREAMBLE -> SYNC -> DATA -> CRC -> IDLE.
  - DATA is skipped when N=0.
  - Each state advances only on a bit_tick that emits the final bit of its last byte.
- IDLE:
  - On start && enable: latch N, set busy=1, clear underrun, set prev_data=0, enter PREAMBLE.
  - start while busy is ignored.
- Encoding:
  - Every data bit d produces two encoded bits: clock = ~prev_data & ~d, then d.
  - Bytes go MSB first; prev_data is updated after each data bit.
  - prev_data carries across byte and state boundaries.
  - One encoded byte is 16 ticks.
- SYNC:
  - SYNC_PATTERN is shifted out verbatim over 16 ticks.
  - Afterwards prev_data = SYNC_PATTERN[0] and CRC = CRC_INIT.
- Output timing: on each bit_tick (with enable), flux_out and flux_valid are registered and appear the next clk. flux_valid is low otherwise.
- Total bits per field = 16*(PREAMBLE_BYTES+1+N+2).
- Payload handshake:
  - 1-byte holding register; data_ready = busy && holding empty && payload bytes still owed.
  - Transfer occurs when data_valid && data_ready on the same cycle; the register is filled the next cycle.
  - data_ready first asserts on entry to SYNC.
- Byte load:
  - At the tick starting each DATA byte, the holding register moves to the shifter and the CRC is updated (MSB-first, CRC_POLY, no reflection, no final XOR).
  - If the register is empty at that tick: substitute 0x00, CRC over 0x00, set underrun=1, continue. The owed-byte count still decrements.
- CRC state:
  - Sends the CRC high byte then the low byte, encoded with the continuing prev_data.
  - After the last CRC bit: done=1 for one cycle, busy=0, data_ready=0, return to IDLE.
- enable low mid-field: freeze with no bit lost; ticks arriving while disabled are dropped.
- reset_n asserted mid-field: immediate abort to the reset values; no done pulse.

Test Plan:
1. PREAMBLE_BYTES=1, N=0, start → bits 0xAAAA, 0xF77A, then CRC 0xFFFF encoded 0x5555, 0x5555; 64 flux_valid pulses; done pulses once; underrun=0.
2. N=1, data 0x00 supplied early → preamble 0xAAAA, sync 0xF77A, payload 0xAAAA, CRC 0xE1F0 with high byte encoded 0x54A9; busy falls the same cycle done pulses.
3. N=9, payload "123456789", source stalls data_valid randomly but always before the byte boundary → CRC bytes 0x29 then 0xB1 decode correctly; underrun=0; exactly 9 data_ready/data_valid transfers.
4. N=2, data_valid never asserted → both payload slots encode 0x00 (0xAAAA); underrun=1 and stays set until next start; CRC equals that of 0x0000.
5. enable dropped for 10 cycles mid-DATA with ticks arriving → no flux_valid during that window; stream resumes bit-exact; total pulse count unchanged. Second start while busy → ignored.
6. reset_n pulled low mid-SYNC → outputs 0 asynchronously; no done. A subsequent start produces a full, correct field.

Source files
------------

// File: rtl/m2fm_field_writer.sv
// rtl/m2fm_field_writer.sv - M2FM field transmitter: encoded preamble, raw sync, handshaked payload, CRC-16
module m2fm_field_writer #(
    parameter int          PREAMBLE_BYTES = 6,
    parameter logic [15:0] SYNC_PATTERN   = 16'hF77A,
    parameter logic [15:0] CRC_POLY       = 16'h1021,
    parameter logic [15:0] CRC_INIT       = 16'hFFFF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       start,
    input  logic [9:0] byte_count,
    input  logic       bit_tick,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       flux_out,
    output logic       flux_valid,
    output logic       busy,
    output logic       done,
    output logic       underrun
);
    typedef enum logic [2:0] {S_IDLE, S_PREAMBLE, S_SYNC, S_DATA, S_CRC} state_t;
    state_t state, state_nxt;

    logic [3:0]  tick_cnt;
    logic [5:0]  byte_cnt, byte_cnt_nxt;
    logic [9:0]  owed;
    logic        prev_data;
    logic [7:0]  hold_data;
    logic        hold_full;
    logic [7:0]  cur_byte;
    logic [15:0] crc;

    logic        tick_en, byte_end, load_tick, last_byte, data_bit, enc_bit;
    logic [7:0]  load_byte, src_byte;

    function automatic logic [15:0] crc_update(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            if (r[15] ^ b[i]) r = {r[14:0], 1'b0} ^ CRC_POLY;
            else              r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    always_comb begin
        tick_en   = enable && bit_tick && (state != S_IDLE);
        byte_end  = tick_en && (tick_cnt == 4'd15);
        load_tick = tick_en && (state == S_DATA) && (tick_cnt == 4'd0);
        load_byte = hold_full ? hold_data : 8'h00;
        // The first clock bit of a payload byte already depends on the byte being loaded
        case (state)
            S_DATA:  src_byte = (tick_cnt == 4'd0) ? load_byte : cur_byte;
            S_CRC:   src_byte = byte_cnt[0] ? crc[7:0] : crc[15:8];
            default: src_byte = 8'h00;
        endcase
        data_bit = src_byte[3'd7 - tick_cnt[3:1]];
        if (state == S_SYNC)    enc_bit = SYNC_PATTERN[4'd15 - tick_cnt];
        else if (!tick_cnt[0])  enc_bit = ~prev_data & ~data_bit;
        else                    enc_bit = data_bit;

        last_byte = 1'b0;
        case (state)
            S_PREAMBLE: last_byte = (byte_cnt == 6'(PREAMBLE_BYTES - 1));
            S_SYNC:     last_byte = 1'b1;
            S_DATA:     last_byte = (owed == 10'd0);
            S_CRC:      last_byte = (byte_cnt == 6'd1);
            default:    last_byte = 1'b0;
        endcase

        state_nxt = state;
        case (state)
            S_IDLE:     if (start) state_nxt = S_PREAMBLE;
            S_PREAMBLE: if (byte_end && last_byte) state_nxt = S_SYNC;
            S_SYNC:     if (byte_end) state_nxt = (owed != 10'd0) ? S_DATA : S_CRC;
            S_DATA:     if (byte_end && last_byte) state_nxt = S_CRC;
            S_CRC:      if (byte_end && last_byte) state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase

        byte_cnt_nxt = byte_cnt;
        if (byte_end) byte_cnt_nxt = last_byte ? 6'd0 : byte_cnt + 6'd1;

        data_ready = busy && enable && !hold_full && (owed != 10'd0) &&
                     ((state == S_SYNC) || (state == S_DATA));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            tick_cnt   <= 4'd0;
            byte_cnt   <= 6'd0;
            owed       <= 10'd0;
            prev_data  <= 1'b0;
            hold_data  <= 8'h00;
            hold_full  <= 1'b0;
            cur_byte   <= 8'h00;
            crc        <= CRC_INIT;
            flux_out   <= 1'b0;
            flux_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            flux_valid <= 1'b0;
            done       <= 1'b0;
            if (enable) begin
                state    <= state_nxt;
                byte_cnt <= byte_cnt_nxt;
                if (state == S_IDLE) begin
                    hold_full <= 1'b0;
                    if (start) begin
                        owed      <= byte_count;
                        busy      <= 1'b1;
                        underrun  <= 1'b0;
                        prev_data <= 1'b0;
                        tick_cnt  <= 4'd0;
                    end
                end else begin
                    if (data_valid && data_ready) begin
                        hold_data <= data_in;
                        hold_full <= 1'b1;
                    end
                    if (tick_en) begin
                        tick_cnt   <= tick_cnt + 4'd1;
                        flux_out   <= enc_bit;
                        flux_valid <= 1'b1;
                        if (state != S_SYNC && tick_cnt[0]) prev_data <= data_bit;
                        if (state == S_SYNC && tick_cnt == 4'd15) begin
                            prev_data <= SYNC_PATTERN[0];
                            crc       <= CRC_INIT;
                        end
                        if (load_tick) begin
                            cur_byte <= load_byte;
                            crc      <= crc_update(crc, load_byte);
                            owed     <= owed - 10'd1;
                            if (hold_full) hold_full <= 1'b0;
                            else           underrun  <= 1'b1;
                        end
                        if (state == S_CRC && byte_end && last_byte) begin
                            busy <= 1'b0;
                            done <= 1'b1;
                        end
                    end
                end
            end
        end
    end
endmodule
